// File: rtl/axi_lite_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_arb_pkg
//  Brief    : Shared state encoding and AXI response codes for the register
//             arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_lite_arb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_SPAN = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_DONE         = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_reg_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Round-robin pick of the first request at or after the pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    input  logic [IDX_W-1:0]   granted_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] w_rot;

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W:0] s);
        if (s >= (IDX_W+1)'(NUM_REQ)) begin
            return IDX_W'(s - (IDX_W+1)'(NUM_REQ));
        end
        return IDX_W'(s);
    endfunction

    // Bit k of the rotated vector is requester (ptr+k) mod NUM_REQ.
    assign w_rot = NUM_REQ'({req_i, req_i} >> ptr_q);

    always_comb begin
        grant_o = ptr_q;
        valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid_o = 1'b1;
                grant_o = f_wrap({1'b0, ptr_q} + (IDX_W+1)'(k));
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = f_wrap({1'b0, granted_i} + (IDX_W+1)'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_reg_arbiter
//  Brief    : Shares a 4-register AXI4-Lite slave between local requesters,
//             one single-word transaction per round-robin grant.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_SPAN = DEF_REG_SPAN
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                resp,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;
    logic [NUM_REQ-1:0] done_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         resp_q;

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
    logic [IDX_W-1:0]   w_gnt;
    logic               w_gnt_valid;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_sel_bad;
    logic [NUM_REQ-1:0] w_new_oh;
    logic [NUM_REQ-1:0] w_cur_oh;
    logic               w_aw_ok;
    logic               w_w_ok;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (ACLK),
        .rst       (ARESET),
        .req_i     (req),
        .advance_i (state_q == ST_DONE),
        .granted_i (gnt_q),
        .grant_o   (w_gnt),
        .valid_o   (w_gnt_valid)
    );

    assign w_sel_addr = w_addr_arr[w_gnt];
    assign w_sel_bad  = (w_sel_addr >= ADDR_W'(REG_SPAN)) || (w_sel_addr[1:0] != 2'b00);
    assign w_new_oh   = NUM_REQ'(1) << w_gnt;
    assign w_cur_oh   = NUM_REQ'(1) << gnt_q;

    // A channel counts as complete once its valid has dropped or is handshaking now.
    assign w_aw_ok = !awvalid_q || m_axi_awready;
    assign w_w_ok  = !wvalid_q  || m_axi_wready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        gnt_q   <= w_gnt;
                        addr_q  <= w_sel_addr;
                        wdata_q <= w_wdata_arr[w_gnt];
                        if (w_sel_bad) begin
                            rdata_q <= '0;
                            resp_q  <= RESP_DECERR;
                            done_q  <= w_new_oh;
                            state_q <= ST_DONE;
                        end else if (req_we[w_gnt]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        resp_q   <= m_axi_bresp;
                        bready_q <= 1'b0;
                        done_q   <= w_cur_oh;
                        state_q  <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q  <= m_axi_rdata;
                        resp_q   <= m_axi_rresp;
                        rready_q <= 1'b0;
                        done_q   <= w_cur_oh;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done          = done_q;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_reg_arbiter
//  Brief    : Self-checking bench: behavioural AXI-Lite slave plus a
//             round-robin / register-file reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_arbiter;

    localparam int N = 2;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [N-1:0]    req, req_we;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]    done;
    logic [31:0]     rdata;
    logic [1:0]      resp;
    logic [31:0]     m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]      m_axi_awprot, m_axi_arprot;
    logic [3:0]      m_axi_wstrb;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic            m_axi_rvalid, m_axi_rready;

    always #5 ACLK = ~ACLK;

    axi_lite_reg_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .REG_SPAN(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rdata(rdata), .resp(resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // ---------------- behavioural slave (ready after a programmable wait) ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_hold = 0, err_en = 0;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        s_aw_got, s_w_got;
    logic [31:0] s_awaddr, s_wdata;
    logic [31:0] s_mem [4];
    wire         aw_hs = m_axi_awvalid && m_axi_awready;
    wire         w_hs  = m_axi_wvalid && m_axi_wready;
    wire [31:0]  s_wa  = aw_hs ? m_axi_awaddr : s_awaddr;
    wire [31:0]  s_wd  = w_hs ? m_axi_wdata : s_wdata;

    assign m_axi_awready = !s_aw_got && !m_axi_bvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = !s_w_got && !m_axi_bvalid && (w_cnt >= w_dly);
    assign m_axi_arready = !m_axi_rvalid && (ar_cnt >= ar_dly);

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
            for (int i = 0; i < 4; i++) s_mem[i] <= '0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            if (m_axi_wvalid && !m_axi_wready)   w_cnt <= w_cnt + 1;
            if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; aw_cnt <= 0; end
            if (w_hs)  begin s_w_got  <= 1'b1; s_wdata  <= m_axi_wdata;  w_cnt  <= 0; end
            if ((s_aw_got || aw_hs) && (s_w_got || w_hs) && !m_axi_bvalid && !b_hold) begin
                s_aw_got <= 1'b0; s_w_got <= 1'b0; m_axi_bvalid <= 1'b1;
                if (err_en && s_wa[3:0] == 4'hC) m_axi_bresp <= 2'b10;
                else begin m_axi_bresp <= 2'b00; s_mem[s_wa[3:2]] <= s_wd; end
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && !m_axi_arready) ar_cnt <= ar_cnt + 1;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt <= 0; m_axi_rvalid <= 1'b1;
                if (err_en && m_axi_araddr[3:0] == 4'hC) begin m_axi_rresp <= 2'b10; m_axi_rdata <= '0; end
                else begin m_axi_rresp <= 2'b00; m_axi_rdata <= s_mem[m_axi_araddr[3:2]]; end
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int          awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, b_hs = 0, viol_cnt = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0;
    wire mon_aw_bad = p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awa);
    wire mon_w_bad  = p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wd);
    wire mon_ar_bad = p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_ara);

    always @(negedge ACLK) begin
        if (ARESET) begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end else begin
            viol_cnt <= viol_cnt + int'(mon_aw_bad) + int'(mon_w_bad) + int'(mon_ar_bad);
            awv_cyc  <= awv_cyc + int'(m_axi_awvalid);
            wv_cyc   <= wv_cyc + int'(m_axi_wvalid);
            arv_cyc  <= arv_cyc + int'(m_axi_arvalid);
            b_hs     <= b_hs + int'(m_axi_bvalid && m_axi_bready);
            p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awa <= m_axi_awaddr;
            p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;  p_wd  <= m_axi_wdata;
            p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_ara <= m_axi_araddr;
        end
    end

    // ---------------- reference model and checking ----------------
    int          checks = 0, errors = 0;
    logic        op_we [N];
    logic [31:0] op_addr [N], op_wdata [N];
    logic [31:0] m_mem [4];
    logic [31:0] m_rdata;
    int          m_ptr;
    int          ord [8];
    int          n_done, got_lat, d_aw, d_w, d_ar, d_b;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_rdata = '0;
        m_ptr   = 0;
    endtask

    function automatic int model_next(input logic [N-1:0] p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (p[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_apply(input int g, output logic [31:0] erd, output logic [1:0] ers);
        logic [31:0] a;
        a = op_addr[g];
        if (a >= 16 || a % 4 != 0) begin m_rdata = '0; ers = 2'b11; end
        else if (err_en && a == 32'hC) begin ers = 2'b10; if (!op_we[g]) m_rdata = '0; end
        else if (op_we[g]) begin m_mem[a / 4] = op_wdata[g]; ers = 2'b00; end
        else begin m_rdata = m_mem[a / 4]; ers = 2'b00; end
        erd = m_rdata;
    endtask

    task automatic do_reset();
        ARESET = 1'b1; req = '0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        model_clear();
    endtask

    task automatic set_op(input int who, input logic we, input logic [31:0] a, input logic [31:0] d);
        op_we[who] = we; op_addr[who] = a; op_wdata[who] = d;
    endtask

    task automatic drive_ops(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            req_we[i] = op_we[i];
            req_addr[i*32 +: 32]  = op_addr[i];
            req_wdata[i*32 +: 32] = op_wdata[i];
        end
        req = mask;
    endtask

    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        logic [31:0]  erd;
        logic [1:0]   ers;
        int cyc, g, gi, aw0, w0, ar0, b0, v0;
        pend = mask; cyc = 0; n_done = 0; got_lat = -1;
        aw0 = awv_cyc; w0 = wv_cyc; ar0 = arv_cyc; b0 = b_hs; v0 = viol_cnt;
        @(posedge ACLK); #1;
        drive_ops(mask);
        while (pend != '0 && cyc < 300) begin
            @(posedge ACLK); #1; cyc++;
            if (done != '0) begin
                g = model_next(pend);
                gi = 0;
                for (int i = 0; i < N; i++) if (done[i]) gi = i;
                if (got_lat < 0) got_lat = cyc;
                check("grant", done, N'(1) << g);
                model_apply(g, erd, ers);
                check("rdata", rdata, erd);
                check("resp", resp, ers);
                got_rdata = rdata; got_resp = resp;
                if (n_done < 8) ord[n_done] = gi;
                n_done++;
                pend[g] = 1'b0;
                pend = pend & ~done;
                req  = req & ~done;
                m_ptr = (g + 1) % N;
            end
        end
        check("batch_timeout", pend, '0);
        req = '0;
        @(negedge ACLK);
        d_aw = awv_cyc - aw0; d_w = wv_cyc - w0; d_ar = arv_cyc - ar0; d_b = b_hs - b0;
        check("protocol", viol_cnt - v0, 0);
        #1;
    endtask

    typedef struct {
        int          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        logic [N-1:0] mask;
        ARESET = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) set_op(i, 1'b0, 32'h0, 32'h0);
        do_reset();

        check("reset_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, done, rdata, resp}, '0);
        check("reset_const", {m_axi_wstrb, m_axi_awprot, m_axi_arprot}, {4'hF, 3'b000, 3'b000});

        tbl[0] = '{0, 1'b1, 32'h0,  32'h1, 32'h0, 2'b00, 3};
        tbl[1] = '{0, 1'b1, 32'h4,  32'h2, 32'h0, 2'b00, 3};
        tbl[2] = '{0, 1'b1, 32'h8,  32'h3, 32'h0, 2'b00, 3};
        tbl[3] = '{0, 1'b1, 32'hC,  32'h4, 32'h0, 2'b00, 3};
        tbl[4] = '{0, 1'b0, 32'h0,  32'h0, 32'h1, 2'b00, 3};
        tbl[5] = '{0, 1'b0, 32'h4,  32'h0, 32'h2, 2'b00, 3};
        tbl[6] = '{0, 1'b0, 32'h8,  32'h0, 32'h3, 2'b00, 3};
        tbl[7] = '{0, 1'b0, 32'hC,  32'h0, 32'h4, 2'b00, 3};
        tbl[8] = '{1, 1'b0, 32'h10, 32'h0, 32'h0, 2'b11, 1};
        tbl[9] = '{1, 1'b0, 32'h6,  32'h0, 32'h0, 2'b11, 1};

        for (int i = 0; i < 10; i++) begin
            set_op(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            run_batch(N'(1) << tbl[i].who);
            check("tbl_rdata", got_rdata, tbl[i].exp_rdata);
            check("tbl_resp", got_resp, tbl[i].exp_resp);
            check("tbl_latency", got_lat, tbl[i].exp_lat);
            check("tbl_done_count", n_done, 1);
            if (tbl[i].exp_resp == 2'b11) check("decerr_no_axi", d_aw + d_ar, 0);
        end

        // Simultaneous writes to the same register from pointer 0.
        do_reset();
        set_op(0, 1'b1, 32'h4, 32'hA5);
        set_op(1, 1'b1, 32'h4, 32'h5A);
        run_batch(2'b11);
        check("sim_order0", ord[0], 0);
        check("sim_order1", ord[1], 1);
        set_op(0, 1'b0, 32'h4, 32'h0);
        run_batch(2'b01);
        check("sim_final_read", got_rdata, 32'h5A);

        // W channel stalled while AW is accepted at once.
        w_dly = 5;
        set_op(0, 1'b1, 32'h8, 32'h1234_5678);
        run_batch(2'b01);
        check("stall_awvalid_cycles", d_aw, 1);
        check("stall_wvalid_cycles", d_w, 6);
        check("stall_b_handshakes", d_b, 1);
        w_dly = 0;

        // Requester 0 keeps requesting, requester 1 asks once.
        do_reset();
        set_op(0, 1'b0, 32'h0, 32'h0);
        set_op(1, 1'b0, 32'h4, 32'h0);
        @(posedge ACLK); #1;
        drive_ops(2'b11);
        n_done = 0; k = 0;
        while (n_done < 3 && k < 100) begin
            @(posedge ACLK); #1; k++;
            if (done != '0) begin
                ord[n_done] = done[1] ? 1 : 0;
                n_done++;
                if (done[1]) req[1] = 1'b0;
                if (n_done == 3) req = '0;
            end
        end
        check("fair_done_count", n_done, 3);
        check("fair_order0", ord[0], 0);
        check("fair_order1", ord[1], 1);
        check("fair_order2", ord[2], 0);
        req = '0;

        // Reset while waiting for the write response.
        do_reset();
        b_hold = 1;
        set_op(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
        @(posedge ACLK); #1;
        drive_ops(2'b01);
        k = 0;
        while (!m_axi_bready && k < 20) begin @(posedge ACLK); #1; k++; end
        check("reach_wr_resp", m_axi_bready, 1'b1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("mid_reset_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                 m_axi_rready, done, rdata, resp}, '0);
        ARESET = 1'b0; req = '0; b_hold = 0;
        model_clear();
        set_op(0, 1'b0, 32'h0, 32'h0);
        run_batch(2'b01);
        check("post_reset_read", {got_rdata, got_resp}, {32'h0, 2'b00});
        check("post_reset_latency", got_lat, 3);

        // Slave error passthrough.
        err_en = 1;
        set_op(0, 1'b1, 32'hC, 32'h77);
        run_batch(2'b01);
        check("slverr_write", got_resp, 2'b10);
        err_en = 0;

        // Randomized batches against the reference model.
        for (int it = 0; it < 60; it++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            err_en = ($urandom_range(0, 3) == 0);
            mask   = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                logic [31:0] a;
                case ($urandom_range(0, 5))
                    4:       a = 32'h10 + 4 * $urandom_range(0, 3);
                    5:       a = 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
                    default: a = 4 * $urandom_range(0, 3);
                endcase
                set_op(i, 1'($urandom_range(0, 1)), a, $urandom);
            end
            run_batch(mask);
            check("rand_done_count", n_done, $countones(mask));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_arbiter.md
Name: axi_lite_reg_arbiter

Overview:
- Shares the 4-register AXI4-Lite slave of the display IP (S00_AXI, 32-bit data, registers at 0x0/0x4/0x8/0xC) between NUM_REQ local requesters.
- Each requester issues single-word register reads or writes over a simple req/done interface. The block grants one requester at a time (round-robin) and sequences one AXI4-Lite transaction per grant on its master port.
- Sits between local sequencers (pattern loader, brightness control) and the slave, alongside the VIP master used in the block-design bench.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (fixed 32)
- REG_SPAN, 16, decoded byte span of the slave; addresses at or above it are not forwarded

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester request, held high until its done pulse
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  flattened byte addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- done  out  NUM_REQ  one-cycle completion pulse per requester
- rdata  out  DATA_W  read data, valid with done
- resp  out  2  AXI response, valid with done
- m_axi_awaddr/awprot/awvalid out, awready in  ADDR_W/3/1/1
- m_axi_wdata/wstrb/wvalid out, wready in  32/4/1/1
- m_axi_bresp/bvalid in, bready out  2/1/1
- m_axi_araddr/arprot/arvalid out, arready in  ADDR_W/3/1/1
- m_axi_rdata/rresp/rvalid in, rready out  32/2/1/1

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: all valids/readies 0, done 0, rdata 0, resp 0, awprot=arprot=3'b000, wstrb=4'hF, FSM in IDLE, round-robin pointer at requester 0.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: if any req is high, grant the first requester at or after the pointer, wrapping modulo NUM_REQ. Latch its we, addr and wdata into internal registers.
  - Out-of-range address (addr >= REG_SPAN) or unaligned address (addr[1:0] != 0): go straight to DONE with resp=2'b11 (DECERR) and rdata=0. No AXI activity.
  - Otherwise go to WR_ADDR_DATA or RD_ADDR on the next edge.
- WR_ADDR_DATA:
  - awvalid and wvalid assert together on entry. Each drops independently the cycle after its own ready handshake; AW and W may complete in either order or the same cycle.
  - Once both have completed, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready, capture bresp, drop bready, go to DONE.
- RD_ADDR: arvalid=1 until the arready handshake, then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready, capture rdata and rresp, go to DONE.
- DONE:
  - Pulse done[granted] for exactly one cycle, with rdata/resp valid in that cycle.
  - Advance the pointer to granted+1 (wrap), then return to IDLE.
  - rdata/resp hold their value until the next DONE. Write completions leave rdata unchanged.
- Latency: minimum 4 cycles from req seen in IDLE to done for a zero-wait slave (grant, addr, resp, done).
- Handshake rules:
  - Valids never drop before their ready.
  - Address and data are stable while valid is high.
  - At most one outstanding AXI transaction.
- Requester rules:
  - A requester that drops req mid-transaction does not abort it; done still pulses.
  - A requester may re-raise req the cycle after done. It is then granted only after other pending requesters (fairness).
- Simultaneous requests: the round-robin order decides. No starvation; worst-case wait is NUM_REQ-1 transactions.
- Slave error (SLVERR) is passed through in resp; no retry.
- ARESET mid-transaction: all outputs go to reset values on the next edge and the in-flight transaction is dropped. The AXI slave is reset by the same ARESET.

Decomposition:
- Shared package axi_lite_arb_pkg:
  - state enum
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - default DATA_W and REG_SPAN
- One sub-module, rr_arbiter: combinational pick plus registered pointer; inputs req and advance, outputs grant index and valid.

Test Plan:
- Requester 0 writes 0x00000001..0x00000004 to 0x0/0x4/0x8/0xC, then reads back -> rdata matches each value, resp=0, one done pulse per access.
- req=2'b11 at the same cycle, both writing 0x4 (r0 data 0xA5, r1 data 0x5A), pointer=0 -> r0 completes first, then r1; final read of 0x4 returns 0x5A.
- Requester 1 reads 0x10 and 0x6 -> done after 1 cycle in DONE, resp=2'b11, rdata=0, no awvalid/arvalid observed.
- Slave holds wready low 5 cycles while awready is immediate -> awvalid drops after its handshake, wvalid held 6 cycles with stable wdata, exactly one bready handshake.
- Requester 0 re-requests continuously while requester 1 requests once -> grants alternate 0,1,0; requester 1 done within 2 transactions.
- ARESET asserted in WR_RESP -> next cycle all valids/readies/done are 0; a subsequent read of 0x0 from requester 0 completes normally.
